// File: rtl/doorlock_pkg.sv
// doorlock_pkg
// Shared definitions for the doorlock display path: digit code constants,
// active-low segment patterns and the single 7-segment encoder used by the
// entry logic and by every display driver.
//
// Segment bit order everywhere is {g,f,e,d,c,b,a}, active-low.
package doorlock_pkg;

   typedef logic [3:0] digit_t;
   typedef logic [6:0] seg_t;

   localparam digit_t DIG_DASH  = 4'hA;
   localparam digit_t DIG_BLANK = 4'hF;

   localparam seg_t SEG_DASH = 7'b0111111;
   localparam seg_t SEG_OFF  = 7'b1111111;

   // Digit code to active-low segment pattern. 0-9 are decimal digits,
   // DIG_DASH marks a masked digit, every other code is blank.
   function automatic seg_t enc(input digit_t d);
      seg_t s;
      case (d)
         4'd0:     s = 7'b1000000;
         4'd1:     s = 7'b1111001;
         4'd2:     s = 7'b0100100;
         4'd3:     s = 7'b0110000;
         4'd4:     s = 7'b0011001;
         4'd5:     s = 7'b0010010;
         4'd6:     s = 7'b0000010;
         4'd7:     s = 7'b1111000;
         4'd8:     s = 7'b0000000;
         4'd9:     s = 7'b0010000;
         DIG_DASH: s = SEG_DASH;
         default:  s = SEG_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer
// Scan timing for the multiplexed display: a prescaler that divides each
// digit slot into SCAN_DIV cycles, the 2-bit slot index, and a frame counter
// that toggles the blink phase every BLINK_DIV frames.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   blink_en     : level; while low the blink counter and phase stay cleared
//   pre_zero     : prescaler is at 0 (guard cycle of the current slot)
//   idx          : current slot index 0..3
//   frame_start  : pre_zero in slot 0 (shadow load cycle)
//   blank_frame  : blinking is enabled and the current frame is dark
module seg_scan_timer
   import doorlock_pkg::*;
#(
   parameter int SCAN_DIV  = 4,
   parameter int BLINK_DIV = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       blink_en,
   output logic       pre_zero,
   output logic [1:0] idx,
   output logic       frame_start,
   output logic       blank_frame
);

   localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
   localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_DIV - 1);
   localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

   // A single-cycle slot would leave no room for the guard cycle.
   if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("seg_scan_timer: SCAN_DIV must be at least 2");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink_div
      $error("seg_scan_timer: BLINK_DIV must be at least 1");
   end

   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [1:0]        idx_q, idx_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              phase_q, phase_d;
   logic              pre_last_s;
   logic              frame_end_s;

   assign pre_last_s  = (pre_q == PRE_LAST);
   assign frame_end_s = pre_last_s && (idx_q == 2'd3);

   assign pre_zero    = (pre_q == '0);
   assign idx         = idx_q;
   assign frame_start = pre_zero && (idx_q == 2'd0);
   assign blank_frame = blink_en && phase_q;

   // Next-state for prescaler, slot index, frame counter and blink phase.
   always_comb begin
      pre_d   = pre_q;
      idx_d   = idx_q;
      fcnt_d  = fcnt_q;
      phase_d = phase_q;

      if (pre_last_s) begin
         pre_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         pre_d = pre_q + PRE_ONE;
      end

      // Cleared immediately when blinking stops so the next blink sequence
      // starts with a lit frame; otherwise only advanced at frame ends.
      if (!blink_en) begin
         fcnt_d  = '0;
         phase_d = 1'b0;
      end else if (frame_end_s) begin
         if (fcnt_q == FCNT_LAST) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + FCNT_ONE;
         end
      end else begin
         fcnt_d  = fcnt_q;
         phase_d = phase_q;
      end
   end

   // Timer state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q   <= '0;
         idx_q   <= 2'd0;
         fcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         fcnt_q  <= fcnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display
// Four-digit multiplexed 7-segment driver. Digits are snapshotted once per
// frame into a shadow register, each slot opens with an all-off guard cycle
// to avoid ghosting, and whole frames go dark while blinking.
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   p10..p13         : digit codes for slots 0..3 (p13 is the leftmost digit)
//   blink_en         : level; when high the display blinks by frames
//   seg[6:0]         : {g,f,e,d,c,b,a}, active-low, registered
//   com[3:0]         : digit commons, active-low, at most one low, registered
module seg_scan_display
   import doorlock_pkg::*;
#(
   parameter int SCAN_DIV  = 4,
   parameter int BLINK_DIV = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] p10,
   input  logic [3:0] p11,
   input  logic [3:0] p12,
   input  logic [3:0] p13,
   input  logic       blink_en,
   output logic [6:0] seg,
   output logic [3:0] com
);

   logic       pre_zero_s;
   logic [1:0] idx_s;
   logic       frame_start_s;
   logic       blank_frame_s;

   seg_scan_timer #(
      .SCAN_DIV  (SCAN_DIV),
      .BLINK_DIV (BLINK_DIV)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .blink_en    (blink_en),
      .pre_zero    (pre_zero_s),
      .idx         (idx_s),
      .frame_start (frame_start_s),
      .blank_frame (blank_frame_s)
   );

   digit_t [3:0] shadow_q, shadow_d;
   logic         lit_start_q, lit_start_d;
   logic [3:0]   com_q, com_d;
   seg_t         seg_q, seg_d;

   assign com = com_q;
   assign seg = seg_q;

   // Shadow capture at frame start; output pattern decided once per slot.
   always_comb begin
      shadow_d    = shadow_q;
      lit_start_d = pre_zero_s;
      com_d       = com_q;
      seg_d       = seg_q;

      if (frame_start_s) begin
         shadow_d = {p13, p12, p11, p10};
      end else begin
         shadow_d = shadow_q;
      end

      // lit_start_q marks the first cycle after the guard (pre == 1). The
      // pattern chosen there is held for the rest of the slot, so seg never
      // changes under a lit digit and a blink release waits for a new slot.
      if (pre_zero_s) begin
         com_d = 4'b1111;
         seg_d = SEG_OFF;
      end else if (lit_start_q) begin
         if (blank_frame_s) begin
            com_d = 4'b1111;
            seg_d = SEG_OFF;
         end else begin
            com_d = ~(4'b0001 << idx_s);
            seg_d = enc(shadow_q[idx_s]);
         end
      end else begin
         com_d = com_q;
         seg_d = seg_q;
      end
   end

   // Shadow and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q    <= {4{DIG_BLANK}};
         lit_start_q <= 1'b0;
         com_q       <= 4'b1111;
         seg_q       <= SEG_OFF;
      end else begin
         shadow_q    <= shadow_d;
         lit_start_q <= lit_start_d;
         com_q       <= com_d;
         seg_q       <= seg_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=4, BLINK_DIV=2.
// Edge e (counted from reset release) shows the state after e-1 cycles:
// frame (e-1)/16, slot ((e-1)%16)/4, guard when (e-1)%4 == 0.
module tb_seg_scan_display;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] p10 = 4'd0;
   logic [3:0] p11 = 4'd0;
   logic [3:0] p12 = 4'd0;
   logic [3:0] p13 = 4'd0;
   logic       blink_en = 1'b0;
   logic [6:0] seg;
   logic [3:0] com;

   int n_cmp = 0;
   int n_bad = 0;

   // Hand-written active-low patterns {g,f,e,d,c,b,a}
   logic [6:0] seg_tbl [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111,
      7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
   };

   seg_scan_display #(
      .SCAN_DIV  (4),
      .BLINK_DIV (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .p10      (p10),
      .p11      (p11),
      .p12      (p12),
      .p13      (p13),
      .blink_en (blink_en),
      .seg      (seg),
      .com      (com)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                             input logic [3:0] d1, input logic [3:0] d0);
      p13 = d3; p12 = d2; p11 = d1; p10 = d0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      set_digits(4'd0, 4'd0, 4'd0, 4'd0);
      blink_en = 1'b0;
      rst = 1'b1;
      tick;
      tick;
      n_cmp++;
      if (com !== 4'b1111) begin n_bad++; $display("FAIL reset_com got %b expected %b", com, 4'b1111); end
      n_cmp++;
      if (seg !== 7'b1111111) begin n_bad++; $display("FAIL reset_seg got %b expected %b", seg, 7'b1111111); end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (com !== 4'b1111) begin n_bad++; $display("FAIL release_com got %b expected %b", com, 4'b1111); end
      n_cmp++;
      if (seg !== 7'b1111111) begin n_bad++; $display("FAIL release_seg got %b expected %b", seg, 7'b1111111); end
      tick;
      n_cmp++;
      if (com !== 4'b1111) begin n_bad++; $display("FAIL guard0_com got %b expected %b", com, 4'b1111); end
      n_cmp++;
      if (seg !== 7'b1111111) begin n_bad++; $display("FAIL guard0_seg got %b expected %b", seg, 7'b1111111); end
   endtask

   // Digits p13..p10 = 1,2,3,4 over two frames
   task automatic test_digits;
      logic [3:0] dig [0:3];
      logic [3:0] ec;
      logic [6:0] es;
      int pos, slot;
      dig[0] = 4'd4; dig[1] = 4'd3; dig[2] = 4'd2; dig[3] = 4'd1;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      do_reset;
      for (int e = 1; e <= 32; e++) begin
         tick;
         pos = (e - 1) % 16;
         slot = pos / 4;
         if (pos % 4 == 0) begin
            ec = 4'b1111; es = 7'b1111111;
         end else begin
            ec = ~(4'b0001 << slot); es = seg_tbl[dig[slot]];
         end
         n_cmp++;
         if (com !== ec) begin n_bad++; $display("FAIL digits_com e=%0d got %b expected %b", e, com, ec); end
         n_cmp++;
         if (seg !== es) begin n_bad++; $display("FAIL digits_seg e=%0d got %b expected %b", e, seg, es); end
      end
   endtask

   // p10 goes 4 -> 9 during slot 2; only the next frame shows it
   task automatic test_midframe_change;
      logic [3:0] dig [0:3];
      logic [3:0] ec;
      logic [6:0] es;
      int pos, slot;
      dig[1] = 4'd3; dig[2] = 4'd2; dig[3] = 4'd1;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      do_reset;
      for (int e = 1; e <= 32; e++) begin
         tick;
         if (e == 10) p10 = 4'd9;
         dig[0] = (e <= 16) ? 4'd4 : 4'd9;
         pos = (e - 1) % 16;
         slot = pos / 4;
         if (pos % 4 == 0) begin
            ec = 4'b1111; es = 7'b1111111;
         end else begin
            ec = ~(4'b0001 << slot); es = seg_tbl[dig[slot]];
         end
         n_cmp++;
         if (com !== ec) begin n_bad++; $display("FAIL change_com e=%0d got %b expected %b", e, com, ec); end
         n_cmp++;
         if (seg !== es) begin n_bad++; $display("FAIL change_seg e=%0d got %b expected %b", e, seg, es); end
      end
   endtask

   // Dash and blank codes keep their commons strobed
   task automatic test_masked;
      logic [3:0] ec;
      logic [6:0] es;
      logic [6:0] slot_seg [0:3];
      int pos, slot;
      slot_seg[0] = 7'b1111111;
      slot_seg[1] = 7'b1111111;
      slot_seg[2] = 7'b0111111;
      slot_seg[3] = 7'b0000000;
      set_digits(4'd8, 4'hA, 4'hF, 4'hC);
      do_reset;
      for (int e = 1; e <= 16; e++) begin
         tick;
         pos = e - 1;
         slot = pos / 4;
         if (pos % 4 == 0) begin
            ec = 4'b1111; es = 7'b1111111;
         end else begin
            ec = ~(4'b0001 << slot); es = slot_seg[slot];
         end
         n_cmp++;
         if (com !== ec) begin n_bad++; $display("FAIL masked_com e=%0d got %b expected %b", e, com, ec); end
         n_cmp++;
         if (seg !== es) begin n_bad++; $display("FAIL masked_seg e=%0d got %b expected %b", e, seg, es); end
      end
   endtask

   // BLINK_DIV=2: frames 0-1 lit, 2-3 dark, 4-5 lit
   task automatic test_blink;
      logic [3:0] dig [0:3];
      logic [3:0] ec;
      logic [6:0] es;
      int pos, slot, frame;
      dig[0] = 4'd4; dig[1] = 4'd3; dig[2] = 4'd2; dig[3] = 4'd1;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      blink_en = 1'b1;
      do_reset;
      for (int e = 1; e <= 96; e++) begin
         tick;
         frame = (e - 1) / 16;
         pos = (e - 1) % 16;
         slot = pos / 4;
         if ((pos % 4 == 0) || frame == 2 || frame == 3) begin
            ec = 4'b1111; es = 7'b1111111;
         end else begin
            ec = ~(4'b0001 << slot); es = seg_tbl[dig[slot]];
         end
         n_cmp++;
         if (com !== ec) begin n_bad++; $display("FAIL blink_com e=%0d got %b expected %b", e, com, ec); end
         n_cmp++;
         if (seg !== es) begin n_bad++; $display("FAIL blink_seg e=%0d got %b expected %b", e, seg, es); end
      end
      blink_en = 1'b0;
   endtask

   // blink_en dropped in dark frame 2 during slot 1: lit again from slot 2
   task automatic test_blink_release;
      logic [3:0] dig [0:3];
      logic [3:0] ec;
      logic [6:0] es;
      int pos, slot;
      dig[0] = 4'd4; dig[1] = 4'd3; dig[2] = 4'd2; dig[3] = 4'd1;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      blink_en = 1'b1;
      do_reset;
      for (int e = 1; e <= 38; e++) tick;
      n_cmp++;
      if (com !== 4'b1111) begin n_bad++; $display("FAIL release_dark_com got %b expected %b", com, 4'b1111); end
      blink_en = 1'b0;
      for (int e = 39; e <= 64; e++) begin
         tick;
         pos = (e - 1) % 16;
         slot = pos / 4;
         if ((pos % 4 == 0) || e < 42) begin
            ec = 4'b1111; es = 7'b1111111;
         end else begin
            ec = ~(4'b0001 << slot); es = seg_tbl[dig[slot]];
         end
         n_cmp++;
         if (com !== ec) begin n_bad++; $display("FAIL unblink_com e=%0d got %b expected %b", e, com, ec); end
         n_cmp++;
         if (seg !== es) begin n_bad++; $display("FAIL unblink_seg e=%0d got %b expected %b", e, seg, es); end
      end
   endtask

   // Asynchronous reset in slot 2, then restart from slot 0
   task automatic test_reset_midframe;
      logic [3:0] dig [0:3];
      logic [3:0] ec;
      logic [6:0] es;
      int pos, slot;
      dig[0] = 4'd4; dig[1] = 4'd3; dig[2] = 4'd2; dig[3] = 4'd1;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      do_reset;
      for (int e = 1; e <= 10; e++) tick;
      n_cmp++;
      if (com !== 4'b1011) begin n_bad++; $display("FAIL pre_rst_com got %b expected %b", com, 4'b1011); end
      n_cmp++;
      if (seg !== 7'b0100100) begin n_bad++; $display("FAIL pre_rst_seg got %b expected %b", seg, 7'b0100100); end
      rst = 1'b1;
      #2;
      n_cmp++;
      if (com !== 4'b1111) begin n_bad++; $display("FAIL async_rst_com got %b expected %b", com, 4'b1111); end
      n_cmp++;
      if (seg !== 7'b1111111) begin n_bad++; $display("FAIL async_rst_seg got %b expected %b", seg, 7'b1111111); end
      tick;
      tick;
      tick;
      rst = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         tick;
         pos = e - 1;
         slot = pos / 4;
         if (pos % 4 == 0) begin
            ec = 4'b1111; es = 7'b1111111;
         end else begin
            ec = ~(4'b0001 << slot); es = seg_tbl[dig[slot]];
         end
         n_cmp++;
         if (com !== ec) begin n_bad++; $display("FAIL restart_com e=%0d got %b expected %b", e, com, ec); end
         n_cmp++;
         if (seg !== es) begin n_bad++; $display("FAIL restart_seg e=%0d got %b expected %b", e, seg, es); end
      end
   endtask

   initial begin
      test_reset;
      test_digits;
      test_midframe_change;
      test_masked;
      test_blink;
      test_blink_release;
      test_reset_midframe;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
